// File: rtl/uart_rx_if.sv
// uart_rx_if -- signal bundle between a UART receiver and its user.
//
// Carries the bit-period setting, the serial line, the frame-format selects,
// the read strobe and the received byte with its status flags. Clock and
// reset stay outside the bundle.
//
//   master : drives clock_divider_i, serial_i, format selects, read_i;
//            observes data_o, ready_o and the error flags (and break_o).
//   slave  : the receiver side (the uart_rx module).
//
// Optional: UART_RX_BREAK_DETECT_EN adds break_o.
interface uart_rx_if #(
  parameter int CLOCK_DIVIDER_WIDTH = 16
);
  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i;
  logic                           serial_i;
  logic                           two_stop_bits_i;
  logic                           parity_bit_i;
  logic                           parity_even_i;
  logic                           read_i;
  logic [7:0]                     data_o;
  logic                           ready_o;
  logic                           parity_error_o;
  logic                           framing_error_o;
  logic                           overrun_error_o;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                           break_o;
`endif

  modport master (
`ifdef UART_RX_BREAK_DETECT_EN
    input  break_o,
`endif
    output clock_divider_i, serial_i, two_stop_bits_i, parity_bit_i,
           parity_even_i, read_i,
    input  data_o, ready_o, parity_error_o, framing_error_o, overrun_error_o
  );

  modport slave (
`ifdef UART_RX_BREAK_DETECT_EN
    output break_o,
`endif
    input  clock_divider_i, serial_i, two_stop_bits_i, parity_bit_i,
           parity_even_i, read_i,
    output data_o, ready_o, parity_error_o, framing_error_o, overrun_error_o
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- UART receiver with configurable bit period and frame format.
//
// Ports:
//   clock_i : sole clock, rising edge.
//   reset_i : asynchronous active-low reset (release is synchronized inside).
//   bus     : uart_rx_if.slave -- divider, serial line, format selects,
//             read strobe, received byte, ready and error flags.
//
// Bit timing: the line is sampled floor(N/2) cycles after the start edge is
// seen, then every N cycles. Divider and format are latched at the start edge
// so mid-frame changes only affect the next frame.
//
// Optional: define UART_RX_BREAK_DETECT_EN to add break_o; an all-low frame
// then raises break_o instead of being delivered.
module uart_rx #(
  parameter int CLOCK_DIVIDER_WIDTH = 16
) (
  input  logic       clock_i,
  input  logic       reset_i,
  uart_rx_if.slave   bus
);
  localparam int W = CLOCK_DIVIDER_WIDTH;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  localparam logic [2:0] S_POST_RESET = 3'd0;
  localparam logic [2:0] S_IDLE       = 3'd1;
  localparam logic [2:0] S_START      = 3'd2;
  localparam logic [2:0] S_DATA       = 3'd3;
  localparam logic [2:0] S_PARITY     = 3'd4;
  localparam logic [2:0] S_STOP       = 3'd5;

  // Reset: asserts immediately, releases two clocks after reset_i rises.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  logic [1:0]   sync;
  logic         rx, rx_prev;
  logic [2:0]   state;
  logic [W-1:0] timer, n_frame, n_live, half;
  logic [2:0]   bit_cnt;
  logic [7:0]   shift;
  logic         two_stop, par_en, par_even;
  logic         pe_acc, fe_acc, par_rx, second_stop, done;
  logic         read_prev, read_edge;
  logic [7:0]   data_q;
  logic         ready_q, pe_q, fe_q, oe_q;
`ifdef UART_RX_BREAK_DETECT_EN
  logic         break_q;
`endif

  assign rx        = sync[1];
  assign n_live    = (bus.clock_divider_i == '0) ? ONE : bus.clock_divider_i;
  assign half      = n_live >> 1;
  assign read_edge = bus.read_i && !read_prev;

  // NOTE: every register below uses <= so all branches see pre-edge values;
  // the delivery block relies on that to let a read clear before a load.
  always_ff @(posedge clock_i or negedge rst_n) begin
    if (!rst_n) begin
      sync        <= 2'b11;
      rx_prev     <= 1'b1;
      state       <= S_POST_RESET;
      timer       <= '0;
      n_frame     <= ONE;
      bit_cnt     <= 3'd0;
      shift       <= 8'h00;
      two_stop    <= 1'b0;
      par_en      <= 1'b0;
      par_even    <= 1'b0;
      pe_acc      <= 1'b0;
      fe_acc      <= 1'b0;
      par_rx      <= 1'b0;
      second_stop <= 1'b0;
      done        <= 1'b0;
      read_prev   <= 1'b0;
      data_q      <= 8'h00;
      ready_q     <= 1'b0;
      pe_q        <= 1'b0;
      fe_q        <= 1'b0;
      oe_q        <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      break_q     <= 1'b0;
`endif
    end else begin
      sync      <= {sync[0], bus.serial_i};
      rx_prev   <= rx;
      read_prev <= bus.read_i;
      done      <= 1'b0;

      case (state)
        S_POST_RESET: begin
          // Require N consecutive high samples before trusting the line.
          if (!rx)                       timer <= '0;
          else if (timer >= n_live - ONE) begin
            timer <= '0;
            state <= S_IDLE;
          end else                       timer <= timer + ONE;
        end
        S_IDLE: begin
`ifdef UART_RX_BREAK_DETECT_EN
          if (rx) break_q <= 1'b0;
`endif
          if (rx_prev && !rx) begin
            state    <= S_START;
            n_frame  <= n_live;
            two_stop <= bus.two_stop_bits_i;
            par_en   <= bus.parity_bit_i;
            par_even <= bus.parity_even_i;
            timer    <= (half == '0) ? '0 : half - ONE;
          end
        end
        S_START: begin
          if (timer != '0)  timer <= timer - ONE;
          else if (rx)      state <= S_IDLE;   // false start, nothing changes
          else begin
            state       <= S_DATA;
            timer       <= n_frame - ONE;
            bit_cnt     <= 3'd0;
            pe_acc      <= 1'b0;
            fe_acc      <= 1'b0;
            par_rx      <= 1'b0;
            second_stop <= 1'b0;
          end
        end
        S_DATA: begin
          if (timer != '0) timer <= timer - ONE;
          else begin
            shift   <= {rx, shift[7:1]};
            timer   <= n_frame - ONE;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= par_en ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (timer != '0) timer <= timer - ONE;
          else begin
            pe_acc <= rx != (par_even ? ^shift : ~^shift);
            par_rx <= rx;
            timer  <= n_frame - ONE;
            state  <= S_STOP;
          end
        end
        S_STOP: begin
          if (timer != '0) timer <= timer - ONE;
`ifdef UART_RX_BREAK_DETECT_EN
          else if (!second_stop && !rx && shift == 8'h00 && !par_rx) begin
            break_q <= 1'b1;                   // break: flag it, no delivery
            state   <= S_IDLE;
          end
`endif
          else if (two_stop && !second_stop) begin
            second_stop <= 1'b1;
            fe_acc      <= fe_acc | !rx;
            timer       <= n_frame - ONE;
          end else begin
            fe_acc <= fe_acc | !rx;
            done   <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Delivery, the cycle after the final stop sample. A read edge in the
      // same cycle frees the holding register first.
      if (read_edge) begin
        ready_q <= 1'b0;
        pe_q    <= 1'b0;
        fe_q    <= 1'b0;
        oe_q    <= 1'b0;
      end
      if (done) begin
        if (!ready_q || read_edge) begin
          data_q  <= shift;
          pe_q    <= pe_acc;
          fe_q    <= fe_acc;
          ready_q <= 1'b1;
        end else begin
          oe_q <= 1'b1;
        end
      end
    end
  end

  // par_rx only feeds break detection; keep it observed in the default build.
  logic unused_par_rx;
  assign unused_par_rx = par_rx;

  assign bus.data_o          = data_q;
  assign bus.ready_o         = ready_q;
  assign bus.parity_error_o  = pe_q;
  assign bus.framing_error_o = fe_q;
  assign bus.overrun_error_o = oe_q;
`ifdef UART_RX_BREAK_DETECT_EN
  assign bus.break_o         = break_q;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed self-checking bench for uart_rx (default build).
module tb_uart_rx;
  logic clock_i = 1'b0;
  logic reset_i = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  uart_rx_if #(.CLOCK_DIVIDER_WIDTH(16)) bus ();

  uart_rx #(.CLOCK_DIVIDER_WIDTH(16)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus.slave)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    bus.serial_i = b;
    repeat (n) @(posedge clock_i);
    #1;
  endtask

  // One stop bit; line returns high and idles long enough for delivery.
  task automatic send_frame(input logic [7:0] d, input int n, input bit p_en,
                            input bit p_even, input logic p_bit, input logic stop_val);
    @(posedge clock_i);
    #1;
    bus.clock_divider_i = 16'(n);
    bus.parity_bit_i    = p_en;
    bus.parity_even_i   = p_even;
    bus.two_stop_bits_i = 1'b0;
    drive_bit(1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(d[i], n);
    if (p_en) drive_bit(p_bit, n);
    drive_bit(stop_val, n);
    bus.serial_i = 1'b1;
    repeat (n + 8) @(posedge clock_i);
    @(negedge clock_i);
  endtask

  task automatic read_pulse();
    @(posedge clock_i);
    #1;
    bus.read_i = 1'b1;
    repeat (3) @(posedge clock_i);
    #1;
    bus.read_i = 1'b0;
    repeat (2) @(posedge clock_i);
    @(negedge clock_i);
  endtask

  initial begin
    bus.clock_divider_i = 16'd4;
    bus.serial_i        = 1'b1;
    bus.two_stop_bits_i = 1'b0;
    bus.parity_bit_i    = 1'b0;
    bus.parity_even_i   = 1'b0;
    bus.read_i          = 1'b0;

    // Reset values
    repeat (3) @(negedge clock_i);
    check("rst_data",  bus.data_o, 8'h00);
    check("rst_ready", 8'(bus.ready_o), 8'h00);
    check("rst_oe",    8'(bus.overrun_error_o), 8'h00);
    check("rst_state", 8'(dut.state), 8'h00);
    reset_i = 1'b1;
    repeat (20) @(negedge clock_i);
    check("post_reset_idle", 8'(dut.state), 8'h01);

    // N=4, 8N1, 0xA5
    send_frame(8'hA5, 4, 1'b0, 1'b0, 1'b0, 1'b1);
    check("a5_data",  bus.data_o, 8'hA5);
    check("a5_ready", 8'(bus.ready_o), 8'h01);
    check("a5_pe",    8'(bus.parity_error_o), 8'h00);
    check("a5_fe",    8'(bus.framing_error_o), 8'h00);
    check("a5_oe",    8'(bus.overrun_error_o), 8'h00);
    read_pulse();
    check("a5_read_ready", 8'(bus.ready_o), 8'h00);

    // N=8, even parity, 0x01 with wrong then right parity bit
    send_frame(8'h01, 8, 1'b1, 1'b1, 1'b0, 1'b1);
    check("par_bad_data", bus.data_o, 8'h01);
    check("par_bad_pe",   8'(bus.parity_error_o), 8'h01);
    check("par_bad_fe",   8'(bus.framing_error_o), 8'h00);
    read_pulse();
    send_frame(8'h01, 8, 1'b1, 1'b1, 1'b1, 1'b1);
    check("par_ok_data",  bus.data_o, 8'h01);
    check("par_ok_ready", 8'(bus.ready_o), 8'h01);
    check("par_ok_pe",    8'(bus.parity_error_o), 8'h00);
    read_pulse();

    // N=8, 0x3C with low stop bit
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fe_data",  bus.data_o, 8'h3C);
    check("fe_flag",  8'(bus.framing_error_o), 8'h01);
    check("fe_ready", 8'(bus.ready_o), 8'h01);
    read_pulse();
    check("fe_cleared", 8'(bus.framing_error_o), 8'h00);

    // N=4, overrun: 0x11 then 0x22 without a read
    send_frame(8'h11, 4, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 4, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_data",  bus.data_o, 8'h11);
    check("ovr_flag",  8'(bus.overrun_error_o), 8'h01);
    check("ovr_ready", 8'(bus.ready_o), 8'h01);
    read_pulse();
    check("ovr_clr_ready", 8'(bus.ready_o), 8'h00);
    check("ovr_clr_oe",    8'(bus.overrun_error_o), 8'h00);
    check("ovr_clr_pe",    8'(bus.parity_error_o), 8'h00);
    check("ovr_clr_fe",    8'(bus.framing_error_o), 8'h00);

    // N=16, 3-cycle glitch, then a valid 0x5A
    @(posedge clock_i);
    #1;
    bus.clock_divider_i = 16'd16;
    bus.serial_i = 1'b0;
    repeat (3) @(posedge clock_i);
    #1;
    bus.serial_i = 1'b1;
    repeat (40) @(negedge clock_i);
    check("glitch_ready", 8'(bus.ready_o), 8'h00);
    check("glitch_state", 8'(dut.state), 8'h01);
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1);
    check("5a_data",  bus.data_o, 8'h5A);
    check("5a_ready", 8'(bus.ready_o), 8'h01);

    // Reset after bit 3 of 0xFF (0x5A left unread so reset has work to do)
    @(posedge clock_i);
    #1;
    bus.clock_divider_i = 16'd4;
    drive_bit(1'b0, 4);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 4);
    reset_i = 1'b0;
    repeat (2) @(negedge clock_i);
    check("mid_rst_data",  bus.data_o, 8'h00);
    check("mid_rst_ready", 8'(bus.ready_o), 8'h00);
    check("mid_rst_state", 8'(dut.state), 8'h00);
    @(posedge clock_i);
    #1;
    reset_i = 1'b1;
    repeat (3) @(negedge clock_i);
    check("rel_still_post_reset", 8'(dut.state), 8'h00);
    repeat (10) @(negedge clock_i);
    check("rel_idle", 8'(dut.state), 8'h01);
    send_frame(8'h81, 4, 1'b0, 1'b0, 1'b0, 1'b1);
    check("81_data",  bus.data_o, 8'h81);
    check("81_ready", 8'(bus.ready_o), 8'h01);
    check("81_fe",    8'(bus.framing_error_o), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLOCK_DIVIDER_WIDTH, default 16, sets the width of clock_divider_i and the internal bit timer.
REQ-002 clock_i  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset_i  input  1  asynchronous, active-low reset.
REQ-004 clock_divider_i  input  CLOCK_DIVIDER_WIDTH  clocks per bit (N); value 0 is treated as 1; N>=4 is required for correct reception.
REQ-005 serial_i  input  1  UART serial line, idle high, asynchronous to clock_i.
REQ-006 two_stop_bits_i, parity_bit_i, parity_even_i  input  1 each  frame format, same meaning as the transmitter's inputs.
REQ-007 read_i  input  1  consumes the held byte, edge-triggered; must go low between reads.
REQ-008 data_o  output  8  last received byte.
REQ-009 ready_o  output  1  data_o holds an unread byte.
REQ-010 parity_error_o, framing_error_o  output  1 each  error status of the byte in data_o.
REQ-011 overrun_error_o  output  1  sticky flag: a frame completed while ready_o was high.

Function
REQ-012 serial_i shall pass through a 2-flop synchronizer; all decisions use the synchronized value (rx).
REQ-013 States shall be POST_RESET, IDLE, START, DATA, PARITY, STOP; undefined encodings shall go to IDLE.
REQ-014 POST_RESET: rx must stay high for N consecutive cycles before entering IDLE; any low sample restarts the count.
REQ-015 IDLE: a high-to-low transition of rx shall enter START and latch the format inputs for the whole frame.
REQ-016 START: rx is sampled floor(N/2) cycles after edge detection; if high, the start is false: return to IDLE with no output change.
REQ-017 Each later bit shall be sampled exactly N cycles after the previous sample; DATA shall take 8 samples, LSB first.
REQ-018 PARITY is entered only when parity is enabled; the expected bit is the XOR of the data (even) or its inverse (odd); a mismatch sets the parity error.
REQ-019 STOP shall take one sample, or two if two stop bits are selected; any low stop sample sets the framing error.
REQ-020 The cycle after the final stop sample: if ready_o=0, load data_o, the parity and framing flags, and set ready_o; if ready_o=1, discard the frame, set overrun_error_o and leave data_o and flags unchanged. Then go to IDLE.
REQ-021 Frames with errors shall still be delivered with their flags set.
REQ-022 A read_i rising edge (read_i high, previously low) shall clear ready_o, parity_error_o, framing_error_o and overrun_error_o on the next cycle; a held-high read_i has no further effect.
REQ-023 If a frame completes in the same cycle as a read edge, the read shall take effect first and the new frame shall load without overrun.
REQ-024 Changes to clock_divider_i or the format inputs mid-frame shall affect only the next frame.

Reset
REQ-025 While reset_i=0: state=POST_RESET, data_o=8'h00, and ready_o, all error flags and the synchronizer flops at 1 (synchronizer) or 0 (all others); a reset mid-frame discards the partial frame.
REQ-026 Deassertion shall be used only after synchronization to clock_i.

Configuration
REQ-027 Macro UART_RX_BREAK_DETECT_EN: when defined, add output break_o (1 bit, reset 0).
- break_o sets when a frame has start, all data bits, any parity bit and the first stop sample all low.
- break_o clears at the first high rx sample in IDLE.
- A break frame is not delivered and does not set overrun.
- Undefined: break_o is absent, and a break frame is delivered as 0x00 with framing_error_o=1.

Verification
REQ-028 N=4, 8N1, send 0xA5 -> data_o=0xA5, ready_o=1, no error flags; read_i pulse -> ready_o=0.
REQ-029 N=8, even parity, send 0x01 with parity bit 0 -> data_o=0x01, parity_error_o=1; same frame with parity bit 1 -> no error.
REQ-030 N=8, send 0x3C with the stop bit driven low -> data_o=0x3C, framing_error_o=1.
REQ-031 N=4, send 0x11 then 0x22 with no read -> data_o=0x11, overrun_error_o=1; read_i pulse -> all flags clear.
REQ-032 N=16, 3-cycle low glitch on an idle line -> no ready_o, state back to IDLE; then a valid 0x5A frame is received correctly.
REQ-033 Assert reset mid-frame (after bit 3 of 0xFF) -> all outputs at reset values; a following 0x81 frame is received only after N idle-high cycles.
